// File: rtl/vx_dcr_boot_seq.sv
// DCR boot sequencer: replays a host-loaded table of DCR writes on start, then tracks socket busy to pulse done.
// Optional launch watchdog enabled by defining VX_DCR_BOOT_TIMEOUT_EN.
`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

module vx_dcr_boot_seq #(
  parameter int NUM_WRITES     = 4,
  parameter int ADDR_WIDTH     = `VX_DCR_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `VX_DCR_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = $clog2(NUM_WRITES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_clear,
  input  logic                  start,
  input  logic                  gpu_busy,
  output logic                  write_valid,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  seq_busy,
  output logic                  done,
  output logic                  timeout
);
  localparam int CNT_W = $clog2(NUM_WRITES + 1);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_BUSY, RUN, DONE} state_t;

  state_t                                 st;
  logic [CNT_W-1:0]                       cnt;
  logic [NUM_WRITES-1:0]                  tvld;
  logic [NUM_WRITES-1:0][ADDR_WIDTH-1:0]  taddr;
  logic [NUM_WRITES-1:0][DATA_WIDTH-1:0]  tdata;
  logic [IDX_W-1:0]                       slot;
  logic                                   cfg_ok;
  logic                                   s0_vld;
  logic [ADDR_WIDTH-1:0]                  s0_addr;
  logic [DATA_WIDTH-1:0]                  s0_data;

  assign cfg_ok = (st == IDLE) && cfg_we && (int'(cfg_idx) < NUM_WRITES);
  assign slot   = cnt[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tvld  <= '0;
      taddr <= '0;
      tdata <= '0;
    end else if (st == IDLE) begin
      if (cfg_clear) tvld <= '0;
      if (cfg_ok) begin
        tvld[cfg_idx]  <= 1'b1;
        taddr[cfg_idx] <= cfg_addr;
        tdata[cfg_idx] <= cfg_data;
      end
    end
  end

  // Slot 0 goes out on the start edge, so it must see a same-cycle clear/write.
  always_comb begin
    s0_vld  = tvld[0] && !cfg_clear;
    s0_addr = taddr[0];
    s0_data = tdata[0];
    if (cfg_ok && cfg_idx == '0) begin
      s0_vld  = 1'b1;
      s0_addr = cfg_addr;
      s0_data = cfg_data;
    end
  end

`ifdef VX_DCR_BOOT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wcnt;
`else
  wire unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      cnt         <= '0;
      write_valid <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      seq_busy    <= 1'b0;
      done        <= 1'b0;
`ifdef VX_DCR_BOOT_TIMEOUT_EN
      wcnt        <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      write_valid <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      done        <= 1'b0;
`ifdef VX_DCR_BOOT_TIMEOUT_EN
      timeout     <= 1'b0;
`endif
      case (st)
        IDLE: if (start) begin
          st       <= WRITE;
          cnt      <= CNT_W'(1);
          seq_busy <= 1'b1;
          if (s0_vld) begin
            write_valid <= 1'b1;
            write_addr  <= s0_addr;
            write_data  <= s0_data;
          end
        end
        WRITE: begin
          if (cnt == CNT_W'(NUM_WRITES)) begin
            st <= WAIT_BUSY;
`ifdef VX_DCR_BOOT_TIMEOUT_EN
            wcnt <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
            if (tvld[slot]) begin
              write_valid <= 1'b1;
              write_addr  <= taddr[slot];
              write_data  <= tdata[slot];
            end
          end
        end
        WAIT_BUSY: begin
          if (gpu_busy) st <= RUN;
`ifdef VX_DCR_BOOT_TIMEOUT_EN
          // Exit through DONE so seq_busy stays high during the timeout pulse.
          else if (wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            st      <= DONE;
            timeout <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        RUN: if (!gpu_busy) begin
          st   <= DONE;
          done <= 1'b1;
        end
        DONE: begin
          st       <= IDLE;
          seq_busy <= 1'b0;
        end
        default: begin
          st       <= IDLE;
          seq_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vx_dcr_boot_seq.sv
// Scoreboard bench for vx_dcr_boot_seq: stimulus queues expected write/done/timeout events, a negedge monitor pops them.
module tb_vx_dcr_boot_seq;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0, reset = 1'b0;
  logic          cfg_we = 1'b0, cfg_clear = 1'b0, start = 1'b0, gpu_busy = 1'b0;
  logic [1:0]    cfg_idx = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          write_valid, seq_busy, done, timeout;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;

  vx_dcr_boot_seq #(.NUM_WRITES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_clear(cfg_clear), .start(start), .gpu_busy(gpu_busy),
    .write_valid(write_valid), .write_addr(write_addr), .write_data(write_data),
    .seq_busy(seq_busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int cyc; logic [AW-1:0] a; logic [DW-1:0] d;} ev_t;
  ev_t q[$];
  int cyc = 0, t0 = 0, checks = 0, passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Event kinds: 0 write, 1 done, 2 timeout. c is the cycle number relative to the start edge.
  task automatic expect_ev(int kind, int c, logic [AW-1:0] a, logic [DW-1:0] d);
    ev_t e;
    e.kind = kind; e.cyc = t0 + c - 1; e.a = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic mon_ev(int kind, logic [AW-1:0] a, logic [DW-1:0] d);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h want none (cyc %0d)", kind, a, d, cyc);
    end else begin
      e = q.pop_front();
      chk("ev_kind", 64'(kind), 64'(e.kind));
      chk("ev_cycle", 64'(cyc), 64'(e.cyc));
      chk("ev_addr", 64'(a), 64'(e.a));
      chk("ev_data", 64'(d), 64'(e.d));
    end
  endtask

  always @(negedge clk) begin
    if (write_valid) mon_ev(0, write_addr, write_data);
    else if (write_addr != '0 || write_data != '0)
      chk("idle_bus_zero", {20'b0, write_addr, write_data}, 64'd0);
    if (done) mon_ev(1, '0, '0);
    if (timeout) mon_ev(2, '0, '0);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_cycle(int k);
    while (cyc < t0 + k - 1) tick();
  endtask

  task automatic load(int idx, logic [AW-1:0] a, logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0; cfg_we = 1'b0; cfg_clear = 1'b0;
    t0 = cyc;
  endtask

  task automatic run_short();
    expect_ev(1, 7, '0, '0);
    at_cycle(5); gpu_busy = 1'b1;
    at_cycle(6); gpu_busy = 1'b0;
    at_cycle(8);
    chk("seq_busy_after_done", 64'(seq_busy), 64'd0);
  endtask

  task automatic expect_orig(logic [DW-1:0] d0);
    expect_ev(0, 1, 12'h001, d0);
    expect_ev(0, 2, 12'h002, 32'h0);
    expect_ev(0, 3, 12'h003, 32'hDEAD);
    expect_ev(0, 4, 12'h004, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (3) tick();
    chk("reset_outputs", {58'b0, write_valid, seq_busy, done, timeout, |write_addr, |write_data}, 64'd0);
    reset = 1'b1;
    tick();

    // Full sequence
    load(0, 12'h001, 32'h80000000);
    load(1, 12'h002, 32'h0);
    load(2, 12'h003, 32'hDEAD);
    load(3, 12'h004, 32'h1);
    launch();
    chk("seq_busy_cycle1", 64'(seq_busy), 64'd1);
    expect_orig(32'h80000000);
    expect_ev(1, 21, '0, '0);
    at_cycle(7);  gpu_busy = 1'b1;
    at_cycle(20); gpu_busy = 1'b0;
    at_cycle(21); chk("seq_busy_in_done", 64'(seq_busy), 64'd1);
    at_cycle(22); chk("seq_busy_after_done", 64'(seq_busy), 64'd0);

    // Inputs ignored while running
    launch();
    expect_orig(32'h80000000);
    expect_ev(1, 11, '0, '0);
    at_cycle(5); gpu_busy = 1'b1;
    at_cycle(8);
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 12'h001; cfg_data = 32'h1234;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    at_cycle(10); gpu_busy = 1'b0;
    at_cycle(12);
    chk("no_relaunch", 64'(seq_busy), 64'd0);
    launch();
    expect_orig(32'h80000000);
    run_short();

    // Sparse table
    cfg_clear = 1'b1; tick(); cfg_clear = 1'b0;
    load(1, 12'h011, 32'hA1);
    load(3, 12'h033, 32'hB3);
    launch();
    expect_ev(0, 2, 12'h011, 32'hA1);
    expect_ev(0, 4, 12'h033, 32'hB3);
    run_short();

    // Clear + write + start in one cycle
    cfg_clear = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd2; cfg_addr = 12'h010; cfg_data = 32'h55;
    launch();
    expect_ev(0, 3, 12'h010, 32'h55);
    run_short();

    // Slot-0 write coincident with start is used by that launch
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 12'h0AA; cfg_data = 32'h77;
    launch();
    expect_ev(0, 1, 12'h0AA, 32'h77);
    expect_ev(0, 3, 12'h010, 32'h55);
    run_short();

    // Reset mid-write
    load(0, 12'h101, 32'h11);
    load(1, 12'h102, 32'h22);
    load(2, 12'h103, 32'h33);
    load(3, 12'h104, 32'h44);
    launch();
    expect_ev(0, 1, 12'h101, 32'h11);
    expect_ev(0, 2, 12'h102, 32'h22);
    at_cycle(2);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("reset_async_outputs", {58'b0, write_valid, seq_busy, done, timeout, |write_addr, |write_data}, 64'd0);
    tick(); tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("idle_after_reset", 64'(seq_busy), 64'd0);
    launch();
    chk("table_cleared_busy", 64'(seq_busy), 64'd1);
    run_short();

    // Watchdog (table is empty here)
    launch();
`ifdef VX_DCR_BOOT_TIMEOUT_EN
    expect_ev(2, 13, '0, '0);
    at_cycle(13); chk("seq_busy_in_timeout", 64'(seq_busy), 64'd1);
    at_cycle(14); chk("seq_busy_after_timeout", 64'(seq_busy), 64'd0);
    at_cycle(30); chk("idle_after_timeout", 64'(seq_busy), 64'd0);
`else
    at_cycle(40);
    chk("wait_indefinite", 64'(seq_busy), 64'd1);
    chk("timeout_tied_low", 64'(timeout), 64'd0);
    gpu_busy = 1'b1;
    expect_ev(1, 42, '0, '0);
    at_cycle(41); gpu_busy = 1'b0;
    at_cycle(43); chk("seq_busy_after_late_done", 64'(seq_busy), 64'd0);
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
